imem_responder: RTL and testbench

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/imem_pkg.sv | 19 +
 rtl/imem_req_fifo.sv | 47 ++++
 rtl/imem_responder.sv | 116 +++++++++++
 tb/tb_imem_responder.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared constants and types for the instruction-memory responder.
// Build option: IMEM_MISALIGN_CHECK_EN (misaligned fetch returns an error NOP).
package imem_pkg;

  localparam logic [31:0] NOP         = 32'h0000_0013;
  localparam int          LAT_DEFAULT = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } entry_t;

endpackage

// File: rtl/imem_req_fifo.sv
// Two-entry in-order request FIFO holding fetched word plus error flag.
// Ready is registered so it never depends on the consumer side this cycle.
module imem_req_fifo
  import imem_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   i_push,
  input  logic   i_pop,
  input  entry_t i_data,
  output entry_t o_head,
  output logic   o_ready,
  output logic   o_nonempty_nx
);

  entry_t     r_buf [2];
  logic       r_wp;
  logic       r_rp;
  logic [1:0] r_cnt;
  logic       r_ready;
  logic [1:0] w_cnt_nx;

  assign w_cnt_nx      = r_cnt + {1'b0, i_push} - {1'b0, i_pop};
  assign o_nonempty_nx = (w_cnt_nx != 2'd0);
  assign o_head        = r_buf[r_rp];
  assign o_ready       = r_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf[0] <= '0;
      r_buf[1] <= '0;
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_cnt    <= 2'd0;
      r_ready  <= 1'b0;
    end else begin
      if (i_push) begin
        r_buf[r_wp] <= i_data;
        r_wp        <= ~r_wp;
      end
      if (i_pop) r_rp <= ~r_rp;
      r_cnt   <= w_cnt_nx;
      r_ready <= (w_cnt_nx != 2'd2);
    end
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction memory responder: read at accept, fixed-latency in-order reply.
// Build option: IMEM_MISALIGN_CHECK_EN flags req_addr[1:0] != 0 as error.
module imem_responder
  import imem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = LAT_DEFAULT
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [31:0]                    req_addr,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [31:0]                    rsp_instr,
  output logic                           rsp_err,
  input  logic                           ld_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr,
  input  logic [31:0]                    ld_data
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   r_mem [DEPTH_WORDS];
  state_t        r_state;
  state_t        w_state_nx;
  logic [3:0]    r_cnt;
  logic [3:0]    w_cnt_nx;
  logic [AW-1:0] w_idx;
  logic          w_oor;
  logic          w_bad;
  logic          w_push;
  logic          w_pop;
  logic          w_nonempty_nx;
  entry_t        w_entry;
  entry_t        w_head;

  always_ff @(posedge clk) begin
    if (ld_en) r_mem[ld_addr] <= ld_data;
  end

  assign w_idx = req_addr[AW+1:2];
  assign w_oor = |req_addr[31:AW+2];

`ifdef IMEM_MISALIGN_CHECK_EN
  assign w_bad = w_oor | (req_addr[1:0] != 2'b00);
`else
  logic w_unused;
  assign w_unused = ^req_addr[1:0];
  assign w_bad    = w_oor;
`endif

  // Old memory word is captured when a load hits the same edge.
  assign w_entry.err  = w_bad;
  assign w_entry.data = w_bad ? NOP : r_mem[w_idx];

  assign w_push = req_valid & req_ready;
  assign w_pop  = rsp_valid & rsp_ready;

  imem_req_fifo u_fifo (
    .clk           (clk),
    .rst           (rst),
    .i_push        (w_push),
    .i_pop         (w_pop),
    .i_data        (w_entry),
    .o_head        (w_head),
    .o_ready       (req_ready),
    .o_nonempty_nx (w_nonempty_nx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (w_nonempty_nx) begin
          w_state_nx = S_WAIT;
          w_cnt_nx   = 4'(LATENCY - 1);
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) w_state_nx = S_RESP;
        else               w_cnt_nx   = r_cnt - 4'd1;
      end
      S_RESP: begin
        if (w_pop) begin
          if (w_nonempty_nx) begin
            w_state_nx = S_WAIT;
            w_cnt_nx   = 4'(LATENCY - 1);
          end else begin
            w_state_nx = S_IDLE;
          end
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    rsp_valid = (r_state == S_RESP);
    rsp_instr = rsp_valid ? w_head.data : 32'd0;
    rsp_err   = rsp_valid & w_head.err;
  end

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: vector table plus hand-written corner sequences.
// Honours IMEM_MISALIGN_CHECK_EN to pick the expected misaligned result.
module tb_imem_responder;
  import imem_pkg::*;

  localparam int DW  = 256;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic        rsp_err;
  logic        ld_en;
  logic [7:0]  ld_addr;
  logic [31:0] ld_data;

  imem_responder #(.DEPTH_WORDS(DW), .LATENCY(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_instr (rsp_instr),
    .rsp_err   (rsp_err),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        err;
  } vec_t;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  exp_t        q[$];
  exp_t        m_e;
  logic [31:0] mdl [DW];
  int          n_vec = 0;
  int          n_err = 0;
  vec_t        vt [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic exp_t model(logic [31:0] a);
    exp_t r;
    logic bad;
    bad = (a >= 32'(4 * DW));
`ifdef IMEM_MISALIGN_CHECK_EN
    bad = bad || (a[1:0] != 2'b00);
`endif
    r.err   = bad;
    r.instr = bad ? NOP : mdl[a[9:2]];
    return r;
  endfunction

  always @(negedge clk) begin
    if (rsp_valid && rsp_ready) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL stale_rsp: got %h with no response expected", rsp_instr);
      end else begin
        m_e = q.pop_front();
        chk("rsp_instr", rsp_instr, m_e.instr);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, m_e.err});
      end
    end else if (!rsp_valid) begin
      chk("idle_outputs", rsp_instr | {31'd0, rsp_err}, 32'd0);
    end
  end

  task automatic load(int idx, logic [31:0] d);
    ld_en   = 1'b1;
    ld_addr = 8'(idx);
    ld_data = d;
    tick();
    ld_en   = 1'b0;
    mdl[idx] = d;
  endtask

  task automatic send(logic [31:0] a, logic [31:0] ei, logic ee);
    exp_t e;
    bit   done;
    done      = 0;
    e.instr   = ei;
    e.err     = ee;
    req_valid = 1'b1;
    req_addr  = a;
    for (int k = 0; k < 50 && !done; k++) begin
      if (req_ready) begin
        q.push_back(e);
        done = 1;
      end
      tick();
    end
    req_valid = 1'b0;
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: addr %h never accepted", a);
    end
  endtask

  task automatic send_m(logic [31:0] a);
    exp_t e;
    e = model(a);
    send(a, e.instr, e.err);
  endtask

  task automatic drain();
    bit done;
    done      = 0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      if (q.size() == 0 && !rsp_valid) done = 1;
      else tick();
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: %0d responses outstanding", q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = 32'd0;
    rsp_ready = 1'b0;
    ld_en     = 1'b0;
    ld_addr   = 8'd0;
    ld_data   = 32'd0;
    for (int i = 0; i < DW; i++) mdl[i] = 32'd0;

    tick();
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rsp_instr", rsp_instr, 32'd0);
    tick();
    rst = 1'b0;
    chk("ready_pre_edge", {31'd0, req_ready}, 32'd0);
    tick();
    chk("ready_post_rst", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < 16; i++) load(i, 32'hC0DE_0000 | 32'(i));
    load(255, 32'hDEAD_BEEF);
    load(5, 32'h00A0_0093);

    // Exact latency from accept into an idle responder.
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'h14;
    chk("lat_ready", {31'd0, req_ready}, 32'd1);
    m_e.instr = 32'h00A0_0093;
    m_e.err   = 1'b0;
    q.push_back(m_e);
    tick();
    req_valid = 1'b0;
    chk("lat_edge1", {31'd0, rsp_valid}, 32'd0);
    tick();
    chk("lat_edge2", {31'd0, rsp_valid}, 32'd0);
    tick();
    chk("lat_edge3", {31'd0, rsp_valid}, 32'd1);
    chk("lat_instr", rsp_instr, 32'h00A0_0093);
    drain();

    vt[0] = '{32'h0000_0000, 32'hC0DE_0000, 1'b0};
    vt[1] = '{32'h0000_0004, 32'hC0DE_0001, 1'b0};
    vt[2] = '{32'h0000_003C, 32'hC0DE_000F, 1'b0};
    vt[3] = '{32'h0000_0014, 32'h00A0_0093, 1'b0};
    vt[4] = '{32'h0000_03FC, 32'hDEAD_BEEF, 1'b0};
    vt[5] = '{32'h0000_0400, 32'h0000_0013, 1'b1};
    vt[6] = '{32'hFFFF_FFFC, 32'h0000_0013, 1'b1};
`ifdef IMEM_MISALIGN_CHECK_EN
    vt[7] = '{32'h0000_0006, 32'h0000_0013, 1'b1};
    vt[8] = '{32'h0000_0009, 32'h0000_0013, 1'b1};
`else
    vt[7] = '{32'h0000_0006, 32'hC0DE_0001, 1'b0};
    vt[8] = '{32'h0000_0009, 32'hC0DE_0002, 1'b0};
`endif
    rsp_ready = 1'b1;
    for (int i = 0; i < 9; i++) send(vt[i].addr, vt[i].instr, vt[i].err);
    drain();

    // Backpressure: two accepts fill the FIFO, third waits for a pop.
    rsp_ready = 1'b0;
    send_m(32'h0);
    send_m(32'h4);
    req_valid = 1'b1;
    req_addr  = 32'h8;
    chk("full_ready", {31'd0, req_ready}, 32'd0);
    tick();
    chk("full_valid", {31'd0, rsp_valid}, 32'd1);
    tick();
    tick();
    chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
    chk("hold_instr", rsp_instr, mdl[0]);
    chk("hold_ready", {31'd0, req_ready}, 32'd0);
    rsp_ready = 1'b1;
    tick();
    chk("ready_after_pop", {31'd0, req_ready}, 32'd1);
    m_e = model(32'h8);
    q.push_back(m_e);
    tick();
    req_valid = 1'b0;
    drain();

    // Load and fetch of the same word on one edge.
    chk("same_edge_ready", {31'd0, req_ready}, 32'd1);
    m_e = model(32'hC);
    q.push_back(m_e);
    ld_en     = 1'b1;
    ld_addr   = 8'd3;
    ld_data   = 32'h1234_5678;
    req_valid = 1'b1;
    req_addr  = 32'hC;
    tick();
    ld_en     = 1'b0;
    req_valid = 1'b0;
    mdl[3]    = 32'h1234_5678;
    send_m(32'hC);
    drain();

    // Reset with two entries queued and the head still counting down.
    rsp_ready = 1'b0;
    send_m(32'h0);
    send_m(32'h4);
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_mid_ready", {31'd0, req_ready}, 32'd0);
    q.delete();
    tick();
    tick();
    rst = 1'b0;
    chk("rel_pre_edge", {31'd0, req_ready}, 32'd0);
    tick();
    chk("rel_ready", {31'd0, req_ready}, 32'd1);
    rsp_ready = 1'b1;
    repeat (6) tick();
    chk("no_stale", {31'd0, rsp_valid}, 32'd0);
    send_m(32'h14);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
